// File: rtl/alu_seq.sv
// Byte-serial sequencer that drives an external 8-bit ALU over 1..NBYTES bytes,
// rippling carry from LSB to MSB and assembling the multi-byte result and status flags.
module alu_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            op,
    input  logic [1:0]            nbytes_m1,
    input  logic [8*NBYTES-1:0]   opa,
    input  logic [8*NBYTES-1:0]   opb,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry_flag,
    output logic                  over_flag,
    output logic                  zero_flag,
    output logic                  cmp_flag,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [7:0]            alu_cins,
    output logic                  alu_oe,
    output logic                  alu_carryin,
    input  logic [7:0]            alu_out,
    input  logic                  alu_carryout,
    input  logic                  alu_overout,
    input  logic                  alu_cmpo
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] MAX_IDX = 2'(NBYTES - 1);

    state_t                   state;
    state_t                   state_nx;
    logic [1:0]               idx;
    logic [1:0]               len;
    logic [1:0]               len_clamped;
    logic [NBYTES-1:0][7:0]   opa_r;
    logic [NBYTES-1:0][7:0]   opb_r;
    logic [NBYTES-1:0][7:0]   result_r;
    logic [7:0]               op_r;
    logic                     carry_reg;
    logic                     zero_acc;
    logic                     last_byte;
    logic [7:0]               a_byte;
    logic [7:0]               b_byte;

    assign len_clamped = ({1'b0, nbytes_m1} > 3'(NBYTES - 1)) ? MAX_IDX : nbytes_m1;
    assign last_byte   = (idx == len);
    assign result      = result_r;

    // Loop-based byte select keeps the index in range for every NBYTES.
    always_comb begin
        a_byte = 8'h00;
        b_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == 2'(i)) begin
                a_byte = opa_r[i];
                b_byte = opb_r[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        busy        = 1'b0;
        done        = 1'b0;
        alu_a       = 8'h00;
        alu_b       = 8'h00;
        alu_cins    = 8'h00;
        alu_oe      = 1'b0;
        alu_carryin = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy        = 1'b1;
                alu_a       = a_byte;
                alu_b       = b_byte;
                alu_cins    = op_r;
                alu_oe      = 1'b1;
                alu_carryin = carry_reg;
                if (last_byte) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // idx holds on the final byte instead of wrapping; the latched length ends the run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= 2'd0;
            len        <= 2'd0;
            opa_r      <= '0;
            opb_r      <= '0;
            op_r       <= 8'h00;
            carry_reg  <= 1'b0;
            zero_acc   <= 1'b0;
            result_r   <= '0;
            carry_flag <= 1'b0;
            over_flag  <= 1'b0;
            zero_flag  <= 1'b0;
            cmp_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa_r     <= opa;
                        opb_r     <= opb;
                        op_r      <= op;
                        len       <= len_clamped;
                        carry_reg <= cin;
                        idx       <= 2'd0;
                        zero_acc  <= 1'b1;
                        result_r  <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx == 2'(i)) begin
                            result_r[i] <= alu_out;
                        end
                    end
                    carry_reg <= alu_carryout;
                    zero_acc  <= zero_acc & (alu_out == 8'h00);
                    if (last_byte) begin
                        carry_flag <= alu_carryout;
                        over_flag  <= alu_overout;
                        cmp_flag   <= alu_cmpo;
                        zero_flag  <= zero_acc & (alu_out == 8'h00);
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a behavioural 8-bit ALU model:
// op bit 0 selects add-with-carry, cmpo flags equal bytes, overout is signed add overflow.
module tb_alu_seq;

    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_ADDC = 8'h01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start2;
    logic [7:0]  op;
    logic [1:0]  nbytes_m1;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        cin;

    logic        busy, done;
    logic [31:0] result;
    logic        carry_flag, over_flag, zero_flag, cmp_flag;
    logic [7:0]  alu_a, alu_b, alu_cins, alu_out;
    logic        alu_oe, alu_carryin, alu_carryout, alu_overout, alu_cmpo;

    logic        busy2, done2;
    logic [15:0] result2;
    logic        carry_flag2, over_flag2, zero_flag2, cmp_flag2;
    logic [7:0]  alu_a2, alu_b2, alu_cins2, alu_out2;
    logic        alu_oe2, alu_carryin2, alu_carryout2, alu_overout2, alu_cmpo2;

    int compared   = 0;
    int mismatched = 0;
    int done_count;

    always #5 clk = ~clk;

    function automatic logic [10:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] o, input logic ci);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + {8'h00, o[0] & ci};
        return {(a == b), ((a[7] == b[7]) && (s[7] != a[7])), s[8], s[7:0]};
    endfunction

    always_comb begin
        {alu_cmpo, alu_overout, alu_carryout, alu_out} = alu_model(alu_a, alu_b, alu_cins, alu_carryin);
        {alu_cmpo2, alu_overout2, alu_carryout2, alu_out2} = alu_model(alu_a2, alu_b2, alu_cins2, alu_carryin2);
    end

    alu_seq #(.NBYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .nbytes_m1(nbytes_m1),
        .opa(opa), .opb(opb), .cin(cin), .busy(busy), .done(done), .result(result),
        .carry_flag(carry_flag), .over_flag(over_flag), .zero_flag(zero_flag), .cmp_flag(cmp_flag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cins(alu_cins), .alu_oe(alu_oe), .alu_carryin(alu_carryin),
        .alu_out(alu_out), .alu_carryout(alu_carryout), .alu_overout(alu_overout), .alu_cmpo(alu_cmpo)
    );

    alu_seq #(.NBYTES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op), .nbytes_m1(nbytes_m1),
        .opa(opa[15:0]), .opb(opb[15:0]), .cin(cin), .busy(busy2), .done(done2), .result(result2),
        .carry_flag(carry_flag2), .over_flag(over_flag2), .zero_flag(zero_flag2), .cmp_flag(cmp_flag2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_cins(alu_cins2), .alu_oe(alu_oe2), .alu_carryin(alu_carryin2),
        .alu_out(alu_out2), .alu_carryout(alu_carryout2), .alu_overout(alu_overout2), .alu_cmpo(alu_cmpo2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one operation on the 4-byte instance and checks every cycle up to one idle cycle after done.
    task automatic applyStimulus(input logic [1:0] len_m1, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic [7:0] o, input logic [31:0] exp_res,
                                 input logic [3:0] exp_flags, input int n, input string name);
        @(negedge clk);
        start = 1'b1; nbytes_m1 = len_m1; opa = a; opb = b; cin = c; op = o;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            checkOutput($sformatf("%s busy c%0d", name, k), {31'd0, busy}, {31'd0, k <= n});
            checkOutput($sformatf("%s done c%0d", name, k), {31'd0, done}, {31'd0, k == n + 1});
            checkOutput($sformatf("%s alu_oe c%0d", name, k), {31'd0, alu_oe}, {31'd0, k <= n});
            if (k <= n) begin
                checkOutput($sformatf("%s alu_a c%0d", name, k), {24'd0, alu_a}, {24'd0, a[8*(k-1) +: 8]});
                checkOutput($sformatf("%s alu_cins c%0d", name, k), {24'd0, alu_cins}, {24'd0, o});
            end
            if (k == 1) begin
                checkOutput($sformatf("%s alu_carryin c1", name), {31'd0, alu_carryin}, {31'd0, c});
            end
            if (k == n + 1) begin
                checkOutput($sformatf("%s result", name), result, exp_res);
                checkOutput($sformatf("%s flags", name),
                            {28'd0, carry_flag, over_flag, zero_flag, cmp_flag}, {28'd0, exp_flags});
            end
        end
        @(negedge clk);
        checkOutput($sformatf("%s idle busy", name), {31'd0, busy | done}, 32'd0);
        checkOutput($sformatf("%s idle result", name), result, exp_res);
        checkOutput($sformatf("%s idle alu_a", name), {24'd0, alu_a}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; op = 8'h00; nbytes_m1 = 2'd0;
        opa = 32'd0; opb = 32'd0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy/done", {30'd0, busy, done}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset flags", {28'd0, carry_flag, over_flag, zero_flag, cmp_flag}, 32'd0);
        checkOutput("reset alu_oe", {31'd0, alu_oe}, 32'd0);
        checkOutput("reset result2", {16'd0, result2}, 32'd0);
        rst_n = 1'b1;

        applyStimulus(2'd3, 32'h0000FFFF, 32'h00000001, 1'b0, OP_ADDC, 32'h00010000, 4'b0001, 4, "add4");
        applyStimulus(2'd0, 32'h0000007F, 32'h00000001, 1'b0, OP_ADD,  32'h00000080, 4'b0100, 1, "ovf1");
        applyStimulus(2'd1, 32'h00001234, 32'h00000011, 1'b1, OP_ADD,  32'h00001245, 4'b0000, 2, "nocarry2");
        applyStimulus(2'd1, 32'h000000FF, 32'h00000000, 1'b1, OP_ADDC, 32'h00000100, 4'b0001, 2, "cin2");
        applyStimulus(2'd3, 32'hFFFFFFFF, 32'h00000001, 1'b0, OP_ADDC, 32'h00000000, 4'b1010, 4, "wrap4");

        // Reset in cycle 2 of a length-4 run, with start held high while reset is low.
        @(negedge clk);
        start = 1'b1; nbytes_m1 = 2'd3; opa = 32'h11111111; opb = 32'h11111111; cin = 1'b0; op = OP_ADD;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("abort busy c1", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort busy c2", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 start = 1'b1;
        for (int k = 3; k <= 7; k++) begin
            @(negedge clk);
            checkOutput($sformatf("abort busy/done c%0d", k), {30'd0, busy, done}, 32'd0);
            checkOutput($sformatf("abort result c%0d", k), result, 32'd0);
            checkOutput($sformatf("abort flags c%0d", k),
                        {28'd0, carry_flag, over_flag, zero_flag, cmp_flag}, 32'd0);
            checkOutput($sformatf("abort alu_oe c%0d", k), {31'd0, alu_oe}, 32'd0);
            @(posedge clk);
            #1;
            start = 1'b0;
            rst_n = 1'b1;
        end

        // Second start in cycle 2 must be ignored; first operands used throughout.
        @(negedge clk);
        start = 1'b1; nbytes_m1 = 2'd3; opa = 32'h01010101; opb = 32'h01010101; cin = 1'b0; op = OP_ADDC;
        @(posedge clk);
        #1 start = 1'b0;
        done_count = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) begin
                start = 1'b1; opa = 32'hFFFFFFFF; opb = 32'hFFFFFFFF; cin = 1'b1;
            end
            if (k == 3) begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) done_count++;
            checkOutput($sformatf("ignore done c%0d", k), {31'd0, done}, {31'd0, k == 5});
            checkOutput($sformatf("ignore busy c%0d", k), {31'd0, busy}, {31'd0, k <= 4});
            if (k <= 4) begin
                checkOutput($sformatf("ignore alu_a c%0d", k), {24'd0, alu_a}, 32'h01);
            end
            @(posedge clk);
            #1;
        end
        checkOutput("ignore done count", done_count, 32'd1);
        checkOutput("ignore result", result, 32'h02020202);
        checkOutput("ignore flags", {28'd0, carry_flag, over_flag, zero_flag, cmp_flag}, 32'h1);

        // Length request of 4 bytes clamps to 2 on the 2-byte instance.
        @(negedge clk);
        start2 = 1'b1; nbytes_m1 = 2'd3; opa = 32'h12345678; opb = 32'h00000001; cin = 1'b0; op = OP_ADDC;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("clamp busy c%0d", k), {31'd0, busy2}, {31'd0, k <= 2});
            checkOutput($sformatf("clamp done c%0d", k), {31'd0, done2}, {31'd0, k == 3});
        end
        checkOutput("clamp result", {16'd0, result2}, 32'h00005679);
        checkOutput("clamp flags", {28'd0, carry_flag2, over_flag2, zero_flag2, cmp_flag2}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: NBYTES, default 4, maximum operand width in bytes (supported range 1-4).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 start  input  1  request a multi-byte operation; sampled only in IDLE.
REQ-005 op  input  8  ALU control word, forwarded unchanged to alu_cins for every byte.
REQ-006 nbytes_m1  input  2  operation length minus one; values >= NBYTES clamp to NBYTES-1.
REQ-007 opa, opb  input  8*NBYTES  operands; byte 0 is least significant.
REQ-008 cin  input  1  carry into byte 0.
REQ-009 busy  output  1  high while bytes are being issued.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result  output  8*NBYTES  assembled result, held until the next accepted start.
REQ-012 carry_flag, over_flag, zero_flag, cmp_flag  output  1 each  status of the last completed operation.
REQ-013 alu_a, alu_b, alu_cins  output  8 each  operand bytes and control word to the ALU.
REQ-014 alu_oe, alu_carryin  output  1 each  ALU output enable and carry-in.
REQ-015 alu_out  input  8; alu_carryout, alu_overout, alu_cmpo  input  1 each  combinational ALU responses in the same cycle.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-017 IDLE with start=1 SHALL latch opa, opb, op and the clamped length, set carry_reg=cin, set byte index=0, clear all result bytes, and go to RUN.
REQ-018 IDLE with start=0 SHALL remain in IDLE with no register changes.
REQ-019 In RUN, per cycle: alu_a=opa byte[idx], alu_b=opb byte[idx], alu_cins=op, alu_oe=1, alu_carryin=carry_reg.
REQ-020 At each RUN clock edge: result byte[idx] <= alu_out, carry_reg <= alu_carryout, idx <= idx+1.
REQ-021 When idx equals the latched length, RUN SHALL go to DONE and update the flags: carry_flag=alu_carryout, over_flag=alu_overout, cmp_flag=alu_cmpo (all from the final byte), zero_flag=1 iff every issued result byte is 0x00.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 Timing with start in cycle 0: RUN occupies cycles 1..N (N = length in bytes), done=1 in cycle N+1, next start is accepted from cycle N+2.
REQ-024 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-025 start asserted in RUN or DONE SHALL be ignored, with no queuing.
REQ-026 Outside RUN: alu_a, alu_b and alu_cins SHALL be 0x00, and alu_oe and alu_carryin SHALL be 0.
REQ-027 Result bytes above the issued length SHALL read 0x00.
REQ-028 Flags and result SHALL change only at the RUN-to-DONE transition and on an accepted start (result clear only).
REQ-029 Carry chains LSB to MSB for every op; the ALU control word alone decides whether carry is used.
REQ-030 idx SHALL NOT wrap past NBYTES-1; the last byte is determined by the latched length, not by overflow of idx.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, idx=0, carry_reg=0, result=0, and all flags=0, and SHALL drive busy=0 and done=0 from the next cycle.
REQ-032 Reset in RUN or DONE SHALL abort the operation: no done pulse, and partial result discarded (zeroed).
REQ-033 start coincident with rst_n=0 SHALL be ignored.

Verification
REQ-034 Length 4, opa=0x0000FFFF, opb=0x00000001, cin=0, op=ADD-with-carry word -> result=0x00010000, carry=0, zero=0, busy cycles 1-4, done in cycle 5.
REQ-035 Length 4, opa=0xFFFFFFFF, opb=0x00000001, cin=0, ADD-with-carry -> result=0x00000000, carry_flag=1, zero_flag=1.
REQ-036 Length 1, opa=0x7F, opb=0x01, ADD -> result=0x00000080, over_flag=1, done in cycle 2, alu_oe high in cycle 1 only.
REQ-037 start pulsed in cycles 0 and 2 (length 4) -> only one done pulse (cycle 5); the second start is ignored; the operands of the first start are used throughout.
REQ-038 rst_n=0 in cycle 2 of a length-4 operation -> from cycle 3: busy=0, done never asserts, result=0, all flags=0, alu_oe=0.
REQ-039 nbytes_m1=3 with NBYTES=2 -> length clamped to 2: done in cycle 3, upper result bytes 0x00.
